hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 55 +++++
 rtl/hazard_unit_if.sv | 50 +++++
 rtl/hazard_unit_load_use_detect.sv | 26 ++
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
// Shared pipeline register package: FD/DE/EM/MW latch structs, the hazard
// controller state encoding and the stall counter type. Imported by the
// hazard unit and by the pipeline latches.
`timescale 1ns/1ps
package hazard_unit_pkg;

    // Hazard controller states
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } hz_state_e;

    // Width-16 performance counter
    typedef logic [15:0] stall_cnt_t;

    localparam stall_cnt_t STALL_CNT_MAX = 16'hFFFF;

    // Pipeline latch contents; a flush loads the all-zero value of these.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fd_latch_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic        dcuREN;
        logic        dcuWEN;
        logic        halt;
    } de_latch_t;

    typedef struct packed {
        logic [4:0]  wsel;
        logic [31:0] alu_out;
        logic [31:0] store_dat;
        logic        dcuREN;
        logic        dcuWEN;
        logic        redirect;
        logic        halt;
    } em_latch_t;

    typedef struct packed {
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic        wen;
        logic        halt;
    } mw_latch_t;

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if
// Bundles the pipeline status inputs and the latch control outputs of the
// hazard unit.
//   master : pipeline side (drives status, receives enables/flushes)
//   slave  : hazard unit side
// Status  : ihit, dhit, fd_rs, fd_rt, de_dcuREN, de_rt, em_dcuREN,
//           em_dcuWEN, em_redirect, mw_halt
// Control : pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush,
//           em_flush, halted, stall_cnt
`timescale 1ns/1ps
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    logic       ihit;
    logic       dhit;
    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic       de_dcuREN;
    logic [4:0] de_rt;
    logic       em_dcuREN;
    logic       em_dcuWEN;
    logic       em_redirect;
    logic       mw_halt;

    logic       pc_en;
    logic       fd_en;
    logic       de_en;
    logic       em_en;
    logic       mw_en;
    logic       fd_flush;
    logic       de_flush;
    logic       em_flush;
    logic       halted;
    stall_cnt_t stall_cnt;

    modport master (
        output ihit, dhit, fd_rs, fd_rt, de_dcuREN, de_rt,
               em_dcuREN, em_dcuWEN, em_redirect, mw_halt,
        input  pc_en, fd_en, de_en, em_en, mw_en,
               fd_flush, de_flush, em_flush, halted, stall_cnt
    );

    modport slave (
        input  ihit, dhit, fd_rs, fd_rt, de_dcuREN, de_rt,
               em_dcuREN, em_dcuWEN, em_redirect, mw_halt,
        output pc_en, fd_en, de_en, em_en, mw_en,
               fd_flush, de_flush, em_flush, halted, stall_cnt
    );

endinterface

// File: rtl/hazard_unit_load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard detection: the load in DE writes a
// register that the instruction in FD reads. r0 never creates a hazard.
// Ports:
//   i_de_dcuREN  DE latch holds a load
//   i_de_rt      destination of that load
//   i_fd_rs      rs of the FD instruction
//   i_fd_rt      rt of the FD instruction
//   o_load_use   hazard present
`timescale 1ns/1ps
module load_use_detect (
    input  logic       i_de_dcuREN,
    input  logic [4:0] i_de_rt,
    input  logic [4:0] i_fd_rs,
    input  logic [4:0] i_fd_rt,
    output logic       o_load_use
);

    logic w_dst_nonzero;
    logic w_src_match;

    assign w_dst_nonzero = (i_de_rt != 5'd0);
    assign w_src_match   = (i_de_rt == i_fd_rs) || (i_de_rt == i_fd_rt);
    assign o_load_use    = i_de_dcuREN && w_dst_nonzero && w_src_match;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard controller: produces PC/latch enables and flushes from
// cache status, load-use hazards, branch redirects and halt.
// Ports:
//   CLK   core clock, rising edge
//   RST   asynchronous active-high reset
//   bus   hazard_unit_if.slave (status in, enables/flushes/halted/stall_cnt out)
// Build option:
//   HAZARD_PERF_CNT_EN  builds the saturating stall counter; without it
//                       stall_cnt is tied to zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal flow; halt > data miss > redirect > load-use > i-miss
// MEMWAIT | data cache miss outstanding, pipeline frozen until dhit
// HALTED  | core stopped, only RST leaves
`timescale 1ns/1ps
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    hazard_unit_if.slave bus
);

    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_MEMWAIT = MEMWAIT;
    localparam logic [1:0] ST_HALTED  = HALTED;

    logic [1:0] r_state;
    logic       r_halted;
    logic [1:0] w_next_state;

    logic w_load_use;
    logic w_data_miss;

    logic w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en;
    logic w_fd_flush, w_de_flush, w_em_flush;

    load_use_detect u_load_use_detect (
        .i_de_dcuREN (bus.de_dcuREN),
        .i_de_rt     (bus.de_rt),
        .i_fd_rs     (bus.fd_rs),
        .i_fd_rt     (bus.fd_rt),
        .o_load_use  (w_load_use)
    );

    // A hit in the same cycle as the access completes it, no wait needed.
    assign w_data_miss = (bus.em_dcuREN || bus.em_dcuWEN) && !bus.dhit;

    always_comb begin
        w_next_state = r_state;
        w_pc_en      = 1'b0;
        w_fd_en      = 1'b0;
        w_de_en      = 1'b0;
        w_em_en      = 1'b0;
        w_mw_en      = 1'b0;
        w_fd_flush   = 1'b0;
        w_de_flush   = 1'b0;
        w_em_flush   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.mw_halt) begin
                    w_next_state = ST_HALTED;
                end else if (w_data_miss) begin
                    w_next_state = ST_MEMWAIT;
                end else if (bus.em_redirect) begin
                    {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
                    {w_fd_flush, w_de_flush, w_em_flush}          = 3'b111;
                end else if (w_load_use) begin
                    // Hold PC and FD, push a bubble into DE, let EM/MW drain.
                    {w_de_en, w_em_en, w_mw_en} = 3'b111;
                    w_de_flush                  = 1'b1;
                end else if (!bus.ihit) begin
                    // Hold PC; FD takes a bubble while the fetch retries.
                    {w_fd_en, w_de_en, w_em_en, w_mw_en} = 4'b1111;
                    w_fd_flush                           = 1'b1;
                end else begin
                    {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
                end
            end
            ST_MEMWAIT: begin
                if (bus.dhit) begin
                    {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
                    w_next_state = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == ST_HALTED);
        end
    end

    assign bus.pc_en    = w_pc_en;
    assign bus.fd_en    = w_fd_en;
    assign bus.de_en    = w_de_en;
    assign bus.em_en    = w_em_en;
    assign bus.mw_en    = w_mw_en;
    assign bus.fd_flush = w_fd_flush;
    assign bus.de_flush = w_de_flush;
    assign bus.em_flush = w_em_flush;
    assign bus.halted   = r_halted;

`ifdef HAZARD_PERF_CNT_EN
    stall_cnt_t r_stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_state != ST_HALTED) &&
                     (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
`timescale 1ns/1ps
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_unit_if hif ();

    hazard_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (hif)
    );

    int checks     = 0;
    int failures   = 0;
    int exp_stalls = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] en_v();
        return {hif.pc_en, hif.fd_en, hif.de_en, hif.em_en, hif.mw_en};
    endfunction

    function automatic logic [2:0] fl_v();
        return {hif.fd_flush, hif.de_flush, hif.em_flush};
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef HAZARD_PERF_CNT_EN
        return (exp_stalls > 65535) ? 16'hFFFF : 16'(exp_stalls);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk_ctl(input string tag, input logic [4:0] en, input logic [2:0] fl);
        chk({tag, "_en"}, {11'd0, en_v()}, {11'd0, en});
        chk({tag, "_fl"}, {13'd0, fl_v()}, {13'd0, fl});
    endtask

    task automatic idle();
        hif.ihit        = 1'b1;
        hif.dhit        = 1'b1;
        hif.fd_rs       = 5'd0;
        hif.fd_rt       = 5'd0;
        hif.de_dcuREN   = 1'b0;
        hif.de_rt       = 5'd0;
        hif.em_dcuREN   = 1'b0;
        hif.em_dcuWEN   = 1'b0;
        hif.em_redirect = 1'b0;
        hif.mw_halt     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_sat;

        // reset state
        rst = 1'b1;
        idle();
        #2;
        chk("rst_halted", {15'd0, hif.halted}, 16'd0);
        chk("rst_cnt", hif.stall_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_ctl("idle", 5'b11111, 3'b000);
        tick();

        // load-use on rs: one stall cycle, then released
        hif.de_dcuREN = 1'b1; hif.de_rt = 5'd5; hif.fd_rs = 5'd5;
        #1;
        chk_ctl("lu_rs", 5'b00111, 3'b010);
        exp_stalls++;
        tick();
        idle();
        #1;
        chk_ctl("lu_release", 5'b11111, 3'b000);
        // r0 destination never stalls
        hif.de_dcuREN = 1'b1; hif.de_rt = 5'd0; hif.fd_rs = 5'd0; hif.fd_rt = 5'd0;
        #1;
        chk_ctl("lu_r0", 5'b11111, 3'b000);
        tick();
        // load-use on rt
        hif.de_rt = 5'd7; hif.fd_rs = 5'd3; hif.fd_rt = 5'd7;
        #1;
        chk_ctl("lu_rt", 5'b00111, 3'b010);
        exp_stalls++;
        tick();
        // no register match
        hif.fd_rt = 5'd4;
        #1;
        chk_ctl("lu_nomatch", 5'b11111, 3'b000);
        // match but not a load
        hif.de_dcuREN = 1'b0; hif.fd_rt = 5'd7;
        #1;
        chk_ctl("lu_notload", 5'b11111, 3'b000);
        tick();

        // instruction miss
        idle();
        hif.ihit = 1'b0;
        #1;
        chk_ctl("imiss", 5'b01111, 3'b100);
        exp_stalls++;
        tick();

        // redirect alone
        idle();
        hif.em_redirect = 1'b1;
        #1;
        chk_ctl("redir", 5'b11111, 3'b111);
        tick();

        // redirect beats load-use and instruction miss
        hif.ihit = 1'b0; hif.de_dcuREN = 1'b1; hif.de_rt = 5'd5; hif.fd_rs = 5'd5;
        #1;
        chk_ctl("prio_redir", 5'b11111, 3'b111);
        // data miss beats everything below halt
        hif.em_dcuWEN = 1'b1; hif.dhit = 1'b0;
        #1;
        chk_ctl("prio_dmiss", 5'b00000, 3'b000);
        exp_stalls++;
        tick();
        #1;
        chk_ctl("prio_memwait", 5'b00000, 3'b000);
        exp_stalls++;
        tick();
        hif.dhit = 1'b1;
        #1;
        chk_ctl("prio_dhit", 5'b11111, 3'b000);
        tick();
        idle();
        #1;
        chk_ctl("prio_back_run", 5'b11111, 3'b000);
        chk("cnt_a", hif.stall_cnt, exp_cnt());

        // same-cycle hit does not enter MEMWAIT
        hif.em_dcuREN = 1'b1;
        #1;
        chk_ctl("dhit_now", 5'b11111, 3'b000);
        tick();
        hif.em_dcuREN = 1'b0; hif.dhit = 1'b0;
        #1;
        chk_ctl("dhit_now_next", 5'b11111, 3'b000);
        tick();

        // data miss lasting 3 cycles, lower conditions ignored in MEMWAIT
        idle();
        hif.em_dcuREN = 1'b1; hif.dhit = 1'b0;
        #1;
        chk_ctl("dmiss_c1", 5'b00000, 3'b000);
        exp_stalls++;
        tick();
        hif.ihit = 1'b0; hif.em_redirect = 1'b1;
        hif.de_dcuREN = 1'b1; hif.de_rt = 5'd5; hif.fd_rs = 5'd5;
        #1;
        chk_ctl("dmiss_c2", 5'b00000, 3'b000);
        exp_stalls++;
        tick();
        #1;
        chk_ctl("dmiss_c3", 5'b00000, 3'b000);
        exp_stalls++;
        tick();
        hif.dhit = 1'b1;
        #1;
        chk_ctl("dmiss_c4", 5'b11111, 3'b000);
        tick();
        idle();
        #1;
        chk_ctl("dmiss_after", 5'b11111, 3'b000);
        chk("cnt_b", hif.stall_cnt, exp_cnt());
        tick();

        // async reset in the middle of MEMWAIT
        hif.em_dcuREN = 1'b1; hif.dhit = 1'b0;
        #1;
        exp_stalls++;
        tick();
        chk_ctl("ar_memwait", 5'b00000, 3'b000);
        exp_stalls++;
        #3;
        rst = 1'b1;
        #1;
        exp_stalls = 0;
        chk("ar_halted", {15'd0, hif.halted}, 16'd0);
        chk("ar_cnt", hif.stall_cnt, 16'd0);
        idle();
        rst = 1'b0;
        #1;
        chk_ctl("ar_run", 5'b11111, 3'b000);
        tick();
        chk_ctl("ar_no_pending", 5'b11111, 3'b000);

        // halt
        hif.mw_halt = 1'b1;
        #1;
        chk_ctl("halt_req", 5'b00000, 3'b000);
        chk("halt_req_halted", {15'd0, hif.halted}, 16'd0);
        exp_stalls++;
        tick();
        chk("halt_halted", {15'd0, hif.halted}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            hif.mw_halt     = 1'b0;
            hif.ihit        = i[0];
            hif.dhit        = ~i[0];
            hif.em_redirect = i[1];
            hif.em_dcuREN   = i[1];
            #1;
            chk_ctl($sformatf("halt_hold%0d", i), 5'b00000, 3'b000);
            tick();
            chk($sformatf("halt_stay%0d", i), {15'd0, hif.halted}, 16'd1);
        end
        chk("halt_cnt", hif.stall_cnt, exp_cnt());
        rst = 1'b1;
        #1;
        exp_stalls = 0;
        chk("halt_rst", {15'd0, hif.halted}, 16'd0);
        idle();
        rst = 1'b0;
        #1;
        chk_ctl("halt_rst_run", 5'b11111, 3'b000);
        tick();

        // counter saturation (long run only when the counter exists)
`ifdef HAZARD_PERF_CNT_EN
        n_sat = 65535 + 200;
`else
        n_sat = 20;
`endif
        hif.ihit = 1'b0;
        repeat (n_sat) tick();
        exp_stalls += n_sat;
        chk("sat_cnt", hif.stall_cnt, exp_cnt());
        tick();
        exp_stalls++;
        chk("sat_hold", hif.stall_cnt, exp_cnt());
        hif.ihit = 1'b1;
        #1;
        chk_ctl("sat_end_run", 5'b11111, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
